// File: rtl/decode_stage_pkg.sv
// Shared types and the pure decode function for the ULM decode stage.
// Optional feature: DECODER_BUS_WIDE_EN adds the WORD/LONG/QUAD bus moves
// (opcodes 22-27). Without it those opcodes decode as illegal.
package decode_stage_pkg;

    localparam int IR_W_DEF   = 32;
    localparam int DATA_W_DEF = 64;
    localparam int REG_W_DEF  = 4;
    localparam int JMP_W_DEF  = 24;

    localparam logic [7:0] OP_HALT_IMM = 8'h01, OP_HALT_REG = 8'h02, OP_JNZ    = 8'h03, OP_JZ     = 8'h04;
    localparam logic [7:0] OP_JMP      = 8'h05, OP_JB       = 8'h06, OP_JMP_FR = 8'h07, OP_JAE    = 8'h08;
    localparam logic [7:0] OP_LDZWQ    = 8'h10, OP_ADDQ_R   = 8'h11, OP_ADDQ_I = 8'h12, OP_SUBQ_R = 8'h13;
    localparam logic [7:0] OP_SUBQ_I   = 8'h14, OP_LDSWQ    = 8'h15;
    localparam logic [7:0] OP_MOVZBQ   = 8'h20, OP_MOVB     = 8'h21, OP_MOVZWQ = 8'h22, OP_MOVW   = 8'h23;
    localparam logic [7:0] OP_MOVZLQ   = 8'h24, OP_MOVL     = 8'h25, OP_MOVQ_LD = 8'h26, OP_MOVQ_ST = 8'h27;
    localparam logic [7:0] OP_PUTC_R   = 8'h30, OP_PUTC_I   = 8'h31, OP_GETC   = 8'h32;

    typedef enum logic [2:0] {UNIT_NONE, UNIT_CU, UNIT_ALU, UNIT_BUS, UNIT_IO} unit_e;
    typedef enum logic [1:0] {CU_NOP, CU_HALT, CU_REL_JMP, CU_ABS_JMP}         cu_op_e;
    typedef enum logic [1:0] {ALU_NOP, ALU_ADD, ALU_SUB}                       alu_op_e;
    typedef enum logic [1:0] {BUS_NOP, BUS_FETCH, BUS_STORE}                   bus_op_e;
    typedef enum logic [1:0] {IO_NOP, IO_PUTC, IO_GETC}                        io_op_e;
    typedef enum logic [1:0] {RAM_BYTE, RAM_WORD, RAM_LONG, RAM_QUAD}          ram_size_e;
    typedef enum logic       {A_SEL_REG, A_SEL_IMM}                            a_sel_e;

    typedef struct packed {
        unit_e                  unit;
        cu_op_e                 cu_op;
        alu_op_e                alu_op;
        bus_op_e                bus_op;
        io_op_e                 io_op;
        logic [REG_W_DEF-1:0]   reg_s;
        logic [REG_W_DEF-1:0]   reg_b;
        logic [REG_W_DEF-1:0]   reg_a;
        logic [DATA_W_DEF-1:0]  imm;
        ram_size_e              size;
        a_sel_e                 a_sel;
        logic [JMP_W_DEF-1:0]   jmp_offset;
        logic                   illegal;
    } dec_bundle_t;

    // All-zero bundle: every unit idle, no registers, no immediate.
    localparam dec_bundle_t DEC_NOP = '0;

    // Opcodes whose outcome depends on zf/cf and therefore must wait for settled flags.
    function automatic logic is_flag_jump(input logic [7:0] op);
        return op inside {OP_JNZ, OP_JZ, OP_JB, OP_JAE};
    endfunction

    // Memory moves: odd opcodes store, even opcodes fetch; the offset is a 17-bit non-negative value.
    function automatic dec_bundle_t bus_fields(input logic [IR_W_DEF-1:0] ir, input ram_size_e size);
        dec_bundle_t d;
        d            = DEC_NOP;
        d.unit       = UNIT_BUS;
        d.bus_op     = ir[IR_W_DEF-8] ? BUS_STORE : BUS_FETCH;
        d.reg_s      = ir[23:20];
        d.reg_b      = ir[19:16];
        d.imm        = DATA_W_DEF'({1'b0, ir[15:0]});
        d.a_sel      = A_SEL_IMM;
        d.size       = size;
        return d;
    endfunction

    function automatic dec_bundle_t decode(input logic [IR_W_DEF-1:0] ir, input logic zf, input logic cf);
        dec_bundle_t d;
        logic [7:0]  op;
        logic        taken;
        op    = ir[IR_W_DEF-1 -: 8];
        taken = 1'b1;
        d     = DEC_NOP;
        case (op)
            OP_HALT_IMM: begin
                d.unit  = UNIT_CU;
                d.cu_op = CU_HALT;
                d.imm   = DATA_W_DEF'(ir[23:16]);
                d.a_sel = A_SEL_IMM;
            end
            OP_HALT_REG: begin
                d.unit  = UNIT_CU;
                d.cu_op = CU_HALT;
                d.reg_s = ir[23:20];
            end
            OP_JNZ, OP_JZ, OP_JMP, OP_JB, OP_JAE: begin
                case (op)
                    OP_JNZ:  taken = !zf;
                    OP_JZ:   taken = zf;
                    OP_JB:   taken = cf;
                    OP_JAE:  taken = !cf;
                    default: taken = 1'b1;
                endcase
                d.unit       = UNIT_CU;
                d.cu_op      = taken ? CU_REL_JMP : CU_NOP;
                d.jmp_offset = ir[JMP_W_DEF-1:0];
            end
            OP_JMP_FR: begin
                d.unit  = UNIT_CU;
                d.cu_op = CU_ABS_JMP;
                d.reg_s = ir[23:20];
                d.reg_b = ir[19:16];
            end
            OP_LDZWQ, OP_LDSWQ: begin
                d.unit   = UNIT_ALU;
                d.alu_op = ALU_ADD;
                d.reg_s  = ir[23:20];
                d.imm    = (op == OP_LDSWQ) ? DATA_W_DEF'($signed(ir[19:0])) : DATA_W_DEF'(ir[19:0]);
                d.a_sel  = A_SEL_IMM;
            end
            OP_ADDQ_R, OP_SUBQ_R: begin
                d.unit   = UNIT_ALU;
                d.alu_op = (op == OP_SUBQ_R) ? ALU_SUB : ALU_ADD;
                d.reg_s  = ir[23:20];
                d.reg_b  = ir[19:16];
                d.reg_a  = ir[15:12];
            end
            OP_ADDQ_I, OP_SUBQ_I: begin
                d.unit   = UNIT_ALU;
                d.alu_op = (op == OP_SUBQ_I) ? ALU_SUB : ALU_ADD;
                d.reg_s  = ir[23:20];
                d.reg_b  = ir[19:16];
                d.imm    = DATA_W_DEF'(ir[15:0]);
                d.a_sel  = A_SEL_IMM;
            end
            OP_MOVZBQ, OP_MOVB:     d = bus_fields(ir, RAM_BYTE);
`ifdef DECODER_BUS_WIDE_EN
            OP_MOVZWQ, OP_MOVW:     d = bus_fields(ir, RAM_WORD);
            OP_MOVZLQ, OP_MOVL:     d = bus_fields(ir, RAM_LONG);
            OP_MOVQ_LD, OP_MOVQ_ST: d = bus_fields(ir, RAM_QUAD);
`endif
            OP_PUTC_R: begin
                d.unit  = UNIT_IO;
                d.io_op = IO_PUTC;
                d.reg_s = ir[23:20];
            end
            OP_PUTC_I: begin
                d.unit  = UNIT_IO;
                d.io_op = IO_PUTC;
                d.imm   = DATA_W_DEF'(ir[23:16]);
                d.a_sel = A_SEL_IMM;
            end
            OP_GETC: begin
                d.unit  = UNIT_IO;
                d.io_op = IO_GETC;
                d.reg_s = ir[23:20];
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/decode_stage_skid_buf.sv
// Generic two-entry valid/ready skid buffer. The main entry drives the output;
// the skid entry catches one word when the consumer stalls, so in_ready depends
// only on skid occupancy and throughput stays at one word per cycle.
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
    logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
    logic         accept, main_free;

    // Refill main from skid first, then from the input; park in skid only while main is held.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        accept       = in_valid && !skid_valid_q;
        main_free    = !main_valid_q || out_ready;
        if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) main_data_d = in_data;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // State register; synchronous reset flushes both entries.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            // NOTE: data registers are reset too, because the idle output must read as an all-zero word.
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready  = !skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;

endmodule

// File: rtl/decode_stage.sv
// ULM decode stage: decodes one instruction word per cycle into a dec_bundle_t,
// stalls flag-dependent jumps while flags are in flight, and records illegal
// opcodes. Wide bus moves are enabled by defining DECODER_BUS_WIDE_EN.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int IR_W   = 32,
    parameter int DATA_W = 64,
    parameter int REG_W  = 4,
    parameter int JMP_W  = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IR_W-1:0] in_ir,
    input  logic            zf,
    input  logic            cf,
    input  logic            flags_busy,
    output logic            out_valid,
    input  logic            out_ready,
    output dec_bundle_t     out_dec,
    output logic            illegal_seen
);

    if (IR_W != IR_W_DEF || DATA_W != DATA_W_DEF || REG_W != REG_W_DEF || JMP_W != JMP_W_DEF) begin : g_width_mismatch
        $error("decode_stage parameters must match the decode_stage_pkg bundle widths");
    end

    logic        hazard, buf_in_ready, accept;
    logic        illegal_seen_d, illegal_seen_q;
    dec_bundle_t dec_bundle;

    // Hazard stall, combinational decode of the presented word, sticky illegal tracking.
    always_comb begin
        hazard         = flags_busy && is_flag_jump(in_ir[IR_W-1 -: 8]);
        in_ready       = buf_in_ready && !hazard;
        accept         = in_valid && in_ready;
        dec_bundle     = decode(in_ir, zf, cf);
        illegal_seen_d = illegal_seen_q || (accept && dec_bundle.illegal);
    end

    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) illegal_seen_q <= 1'b0;
        else     illegal_seen_q <= illegal_seen_d;
    end

    decode_skid_buf #(.W($bits(dec_bundle_t))) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid && !hazard),
        .in_ready  (buf_in_ready),
        .in_data   (dec_bundle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_dec)
    );

    assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage with directed scenarios.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, zf, cf, flags_busy, out_valid, out_ready, illegal_seen;
    logic [31:0] in_ir;
    dec_bundle_t out_dec;

    int          checks = 0;
    int          failures = 0;
    dec_bundle_t exp_q[$];
    dec_bundle_t sb_exp;
    bit          model_seen = 1'b0;

    logic [7:0] op_list [30] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h10, 8'h11,
                                 8'h12, 8'h13, 8'h14, 8'h15, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25,
                                 8'h26, 8'h27, 8'h30, 8'h31, 8'h32, 8'h00, 8'h09, 8'h1F, 8'h33, 8'hFF};

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir),
        .zf(zf), .cf(cf), .flags_busy(flags_busy), .out_valid(out_valid), .out_ready(out_ready),
        .out_dec(out_dec), .illegal_seen(illegal_seen)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference decode written from the instruction-set rules.
    function automatic dec_bundle_t ref_decode(input logic [31:0] ir, input logic z, input logic c);
        dec_bundle_t e;
        int          op, bus_max;
        bit          go;
        e  = '0;
        op = int'(ir[31:24]);
`ifdef DECODER_BUS_WIDE_EN
        bus_max = 'h27;
`else
        bus_max = 'h21;
`endif
        if (op >= 'h01 && op <= 'h08) begin
            e.unit = UNIT_CU;
            if (op == 'h01) begin
                e.cu_op = CU_HALT; e.imm = 64'(ir[23:16]); e.a_sel = A_SEL_IMM;
            end else if (op == 'h02) begin
                e.cu_op = CU_HALT; e.reg_s = ir[23:20];
            end else if (op == 'h07) begin
                e.cu_op = CU_ABS_JMP; e.reg_s = ir[23:20]; e.reg_b = ir[19:16];
            end else begin
                go = (op == 'h05) || (op == 'h03 && !z) || (op == 'h04 && z) || (op == 'h06 && c) || (op == 'h08 && !c);
                e.cu_op = go ? CU_REL_JMP : CU_NOP;
                e.jmp_offset = ir[23:0];
            end
        end else if (op >= 'h10 && op <= 'h15) begin
            e.unit   = UNIT_ALU;
            e.alu_op = (op == 'h13 || op == 'h14) ? ALU_SUB : ALU_ADD;
            e.reg_s  = ir[23:20];
            if (op == 'h10 || op == 'h15) begin
                e.imm   = (op == 'h15 && ir[19]) ? {44'hFFF_FFFF_FFFF, ir[19:0]} : {44'h0, ir[19:0]};
                e.a_sel = A_SEL_IMM;
            end else if (op == 'h11 || op == 'h13) begin
                e.reg_b = ir[19:16]; e.reg_a = ir[15:12];
            end else begin
                e.reg_b = ir[19:16]; e.imm = {48'h0, ir[15:0]}; e.a_sel = A_SEL_IMM;
            end
        end else if (op >= 'h20 && op <= bus_max) begin
            e.unit   = UNIT_BUS;
            e.bus_op = (op % 2 == 1) ? BUS_STORE : BUS_FETCH;
            e.size   = ram_size_e'((op - 'h20) / 2);
            e.reg_s  = ir[23:20];
            e.reg_b  = ir[19:16];
            e.imm    = {48'h0, ir[15:0]};
            e.a_sel  = A_SEL_IMM;
        end else if (op == 'h30 || op == 'h32) begin
            e.unit  = UNIT_IO;
            e.io_op = (op == 'h30) ? IO_PUTC : IO_GETC;
            e.reg_s = ir[23:20];
        end else if (op == 'h31) begin
            e.unit = UNIT_IO; e.io_op = IO_PUTC; e.imm = 64'(ir[23:16]); e.a_sel = A_SEL_IMM;
        end else begin
            e.illegal = 1'b1;
        end
        return e;
    endfunction

    function automatic bit ref_hazard(input logic [31:0] ir, input logic busy);
        int op;
        op = int'(ir[31:24]);
        return busy && (op == 'h03 || op == 'h04 || op == 'h06 || op == 'h08);
    endfunction

    // Scoreboard and monitor: occupancy-based handshake model plus in-order bundle comparison.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_seen = 1'b0;
        end else begin
            check("illegal_seen", 128'(illegal_seen), 128'(model_seen));
            check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
            check("in_ready", 128'(in_ready), 128'(exp_q.size() < 2 && !ref_hazard(in_ir, flags_busy)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    sb_exp = exp_q.pop_front();
                    check("out_dec", 128'(out_dec), 128'(sb_exp));
                end
            end
            if (in_valid && in_ready) begin
                sb_exp = ref_decode(in_ir, zf, cf);
                exp_q.push_back(sb_exp);
                if (sb_exp.illegal) model_seen = 1'b1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] ir);
        cyc();
        in_valid = 1'b1;
        in_ir    = ir;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        flags_busy = 1'b0;
        while (exp_q.size() > 0 && n < 20) begin
            cyc();
            n++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        logic [31:0] rnd;
        int          n;
        rst = 1'b1; in_valid = 1'b0; in_ir = '0; zf = 1'b0; cf = 1'b0; flags_busy = 1'b0; out_ready = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_in_ready", 128'(in_ready), 128'(1));
        check("reset_illegal_seen", 128'(illegal_seen), 128'(0));
        check("reset_out_dec", 128'(out_dec), 128'(0));

        // ldzwq 0 with a free consumer: one-cycle latency, ALU add of an immediate.
        out_ready = 1'b1;
        send_one(32'h1000_0000);
        check("t1_out_valid", 128'(out_valid), 128'(1));
        check("t1_unit", 128'(out_dec.unit), 128'(UNIT_ALU));
        check("t1_alu_op", 128'(out_dec.alu_op), 128'(ALU_ADD));
        check("t1_a_sel", 128'(out_dec.a_sel), 128'(A_SEL_IMM));
        check("t1_imm", 128'(out_dec.imm), 128'(0));

        // Eight back-to-back words at full rate.
        for (int i = 0; i < 8; i++) begin
            cyc();
            rnd = $urandom;
            in_valid = 1'b1;
            in_ir = {op_list[$urandom_range(0, 29)], rnd[23:0]};
            @(negedge clk);
            check("t2_in_ready", 128'(in_ready), 128'(1));
            if (i > 0) check("t2_out_valid", 128'(out_valid), 128'(1));
        end
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_last_valid", 128'(out_valid), 128'(1));
        cyc();
        @(negedge clk);
        check("t2_idle", 128'(out_valid), 128'(0));

        // Consumer stalled: two words fit, the third waits until the consumer resumes.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            in_valid = 1'b1;
            in_ir = 32'h3000_0000 | (32'(i + 1) << 20);
            @(negedge clk);
            check("t3_in_ready", 128'(in_ready), 128'(i < 2));
        end
        cyc();
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t3_release", 128'(in_ready), 128'(1));
        cyc();
        in_valid = 1'b0;
        drain();

        // jz stalled by in-flight flags, then resolved from zf at accept.
        cyc();
        in_valid = 1'b1; in_ir = 32'h0400_0010; flags_busy = 1'b1; zf = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall", 128'(in_ready), 128'(0));
            cyc();
        end
        flags_busy = 1'b0;
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        check("t4_taken_op", 128'(out_dec.cu_op), 128'(CU_REL_JMP));
        check("t4_offset", 128'(out_dec.jmp_offset), 128'(24'h10));
        zf = 1'b0;
        send_one(32'h0400_0010);
        check("t4_not_taken", 128'(out_dec.cu_op), 128'(CU_NOP));

        // Illegal opcode is still emitted and sets the sticky flag.
        send_one(32'h1F00_0000);
        check("t5_illegal", 128'(out_dec.illegal), 128'(1));
        check("t5_unit", 128'(out_dec.unit), 128'(UNIT_NONE));
        cyc();
        @(negedge clk);
        check("t5_sticky", 128'(illegal_seen), 128'(1));

        // Sign-extended 20-bit immediate and the QUAD fetch.
        send_one(32'h1518_0000);
        check("t6_ldswq_imm", 128'(out_dec.imm), 128'(64'hFFFF_FFFF_FFF8_0000));
        send_one(32'h2632_0008);
`ifdef DECODER_BUS_WIDE_EN
        check("t6_quad_size", 128'(out_dec.size), 128'(RAM_QUAD));
        check("t6_quad_op", 128'(out_dec.bus_op), 128'(BUS_FETCH));
`else
        check("t6_quad_illegal", 128'(out_dec.illegal), 128'(1));
`endif

        // Randomized traffic with random back-pressure and flag hazards.
        for (int i = 0; i < 600; i++) begin
            cyc();
            rnd        = $urandom;
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 9) < 7);
            flags_busy = ($urandom_range(0, 3) == 0);
            zf         = 1'($urandom_range(0, 1));
            cf         = 1'($urandom_range(0, 1));
            in_ir      = {op_list[$urandom_range(0, 29)], rnd[23:0]};
        end
        drain();
        check("sticky_before_rst", 128'(illegal_seen), 128'(1));

        // Reset with two bundles buffered: everything is flushed.
        out_ready = 1'b0;
        cyc(); in_valid = 1'b1; in_ir = 32'h1F00_0000;
        cyc(); in_ir = 32'h3100_4100;
        cyc(); in_valid = 1'b0; rst = 1'b1;
        cyc(); rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_illegal_seen", 128'(illegal_seen), 128'(0));
        out_ready = 1'b1;
        send_one(32'h3100_4100);
        check("post_rst_io", 128'(out_dec.io_op), 128'(IO_PUTC));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
